// File: rtl/conv3x3_window_gen.sv
// rtl/conv3x3_window_gen.sv - 3x3 sliding-window generator over a raster pixel stream
module conv3x3_window_gen #(
   parameter int DATA_WIDTH = 32,
   parameter int IMG_W      = 28,
   parameter int IMG_H      = 28
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  valid_in,
   input  logic                  sof_in,
   output logic [DATA_WIDTH-1:0] win0,
   output logic [DATA_WIDTH-1:0] win1,
   output logic [DATA_WIDTH-1:0] win2,
   output logic [DATA_WIDTH-1:0] win3,
   output logic [DATA_WIDTH-1:0] win4,
   output logic [DATA_WIDTH-1:0] win5,
   output logic [DATA_WIDTH-1:0] win6,
   output logic [DATA_WIDTH-1:0] win7,
   output logic [DATA_WIDTH-1:0] win8,
   output logic                  valid_out,
   output logic                  frame_last
);

   localparam int CW = $clog2(IMG_W);
   localparam int RW = $clog2(IMG_H);
   localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

   logic [CW-1:0] col, col_eff, col_nxt;
   logic [RW-1:0] row, row_eff, row_nxt;

   // lb_a holds the previous row, lb_b the one before it; no reset needed since
   // valid_out is only raised once both have been rewritten for the current frame
   logic [DATA_WIDTH-1:0] lb_a [IMG_W];
   logic [DATA_WIDTH-1:0] lb_b [IMG_W];
   logic [DATA_WIDTH-1:0] tap_a, tap_b;

   // sof_in forces the accepted pixel to (0,0); compute its position and the following one
   always_comb begin
      col_eff = sof_in ? '0 : col;
      row_eff = sof_in ? '0 : row;
      tap_a   = lb_a[col_eff];
      tap_b   = lb_b[col_eff];
      col_nxt = col_eff + 1'b1;
      row_nxt = row_eff;
      if (col_eff == COL_LAST) begin
         col_nxt = '0;
         row_nxt = (row_eff == ROW_LAST) ? '0 : row_eff + 1'b1;
      end
   end

   // line buffers: read-before-write at the current column, age the row down one buffer
   always_ff @(posedge clk) begin
      if (valid_in) begin
         lb_b[col_eff] <= lb_a[col_eff];
         lb_a[col_eff] <= data_in;
      end
   end

   // position counters, window shift registers and the output strobes
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         col        <= '0;
         row        <= '0;
         win0       <= '0;
         win1       <= '0;
         win2       <= '0;
         win3       <= '0;
         win4       <= '0;
         win5       <= '0;
         win6       <= '0;
         win7       <= '0;
         win8       <= '0;
         valid_out  <= 1'b0;
         frame_last <= 1'b0;
      end else if (valid_in) begin
         col        <= col_nxt;
         row        <= row_nxt;
         win0       <= win1;
         win1       <= win2;
         win2       <= tap_b;
         win3       <= win4;
         win4       <= win5;
         win5       <= tap_a;
         win6       <= win7;
         win7       <= win8;
         win8       <= data_in;
         valid_out  <= (row_eff >= RW'(2)) && (col_eff >= CW'(2));
         frame_last <= (row_eff == ROW_LAST) && (col_eff == COL_LAST);
      end else begin
         valid_out  <= 1'b0;
         frame_last <= 1'b0;
      end
   end

endmodule

// File: tb/tb_conv3x3_window_gen.sv
// tb/tb_conv3x3_window_gen.sv - directed and reference-model checks of conv3x3_window_gen
module tb_conv3x3_window_gen;

   typedef logic [9*32:0] wv_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic [31:0] data_in;
   logic        valid_in, sof_in;
   logic [31:0] a0, a1, a2, a3, a4, a5, a6, a7, a8;
   logic        a_vld, a_fl;
   logic [31:0] b0, b1, b2, b3, b4, b5, b6, b7, b8;
   logic        b_vld, b_fl;

   int  n_checks = 0;
   int  n_fail   = 0;
   int  fl_bad   = 0;
   bit  chk_gap  = 1'b0;
   wv_t a_prev;
   wv_t a_q[$];
   wv_t b_q[$];
   logic [31:0] px [784];

   conv3x3_window_gen #(.DATA_WIDTH(32), .IMG_W(5), .IMG_H(4)) dut_small (
      .clk(clk), .rst(rst), .data_in(data_in), .valid_in(valid_in), .sof_in(sof_in),
      .win0(a0), .win1(a1), .win2(a2), .win3(a3), .win4(a4), .win5(a5),
      .win6(a6), .win7(a7), .win8(a8), .valid_out(a_vld), .frame_last(a_fl)
   );

   conv3x3_window_gen dut_full (
      .clk(clk), .rst(rst), .data_in(data_in), .valid_in(valid_in), .sof_in(sof_in),
      .win0(b0), .win1(b1), .win2(b2), .win3(b3), .win4(b4), .win5(b5),
      .win6(b6), .win7(b7), .win8(b8), .valid_out(b_vld), .frame_last(b_fl)
   );

   task automatic assert_eq(input string tag, input wv_t obs, input wv_t exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic wv_t win_a();
      return wv_t'({a0, a1, a2, a3, a4, a5, a6, a7, a8});
   endfunction

   function automatic wv_t pack_a();
      return {a_fl, a0, a1, a2, a3, a4, a5, a6, a7, a8};
   endfunction

   function automatic wv_t pack_b();
      return {b_fl, b0, b1, b2, b3, b4, b5, b6, b7, b8};
   endfunction

   // expected window number idx of a 5x4 frame whose pixels are base, base+1, ...
   function automatic wv_t exp_small(input int base, input int idx);
      int  r, c;
      wv_t v;
      r = 2 + idx / 3;
      c = 2 + idx % 3;
      v = wv_t'(r == 3 && c == 4);
      for (int k = 0; k < 9; k++)
         v = (v << 32) | wv_t'(base + (r - 2 + k / 3) * 5 + (c - 2 + k % 3));
      return v;
   endfunction

   task automatic check_frame(input string tag, input int base, input int first);
      for (int i = 0; i < 6; i++)
         if (first + i < a_q.size())
            assert_eq(tag, a_q[first + i], exp_small(base, i));
   endtask

   task automatic send(input logic [31:0] d, input logic s);
      @(negedge clk);
      data_in  = d;
      valid_in = 1'b1;
      sof_in   = s;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         data_in  = '0;
         valid_in = 1'b0;
         sof_in   = 1'b0;
      end
   endtask

   // capture windows and watch gap behaviour just after each rising edge
   always @(posedge clk) begin
      #1;
      if (a_vld) a_q.push_back(pack_a());
      if (b_vld) b_q.push_back(pack_b());
      if ((a_fl && !a_vld) || (b_fl && !b_vld)) fl_bad++;
      if (chk_gap && !valid_in) begin
         assert_eq("gap_valid", wv_t'(a_vld), wv_t'(0));
         assert_eq("gap_hold", win_a(), a_prev);
      end
      a_prev = win_a();
   end

   initial begin
      rst      = 1'b1;
      data_in  = '0;
      valid_in = 1'b0;
      sof_in   = 1'b0;
      repeat (2) @(negedge clk);
      assert_eq("reset_win", win_a(), wv_t'(0));
      assert_eq("reset_valid", wv_t'(a_vld), wv_t'(0));
      assert_eq("reset_fl", wv_t'(a_fl), wv_t'(0));
      rst = 1'b0;

      // single frame, latency of the first window
      a_q.delete();
      for (int i = 0; i < 20; i++) begin
         send(32'(i), i == 0);
         @(posedge clk);
         #1;
         if (i == 11) assert_eq("t1_pre_latency", wv_t'(a_vld), wv_t'(0));
         if (i == 12) assert_eq("t1_latency", wv_t'(a_vld), wv_t'(1));
      end
      idle(3);
      assert_eq("t1_count", wv_t'(a_q.size()), wv_t'(6));
      check_frame("t1_win", 0, 0);

      // same frame with three idle cycles after every pixel
      chk_gap = 1'b1;
      a_q.delete();
      for (int i = 0; i < 20; i++) begin
         send(32'(i), i == 0);
         idle(3);
      end
      chk_gap = 1'b0;
      assert_eq("t2_count", wv_t'(a_q.size()), wv_t'(6));
      check_frame("t2_win", 0, 0);

      // two frames back to back without sof_in
      a_q.delete();
      for (int i = 0; i < 20; i++) send(32'(i), 1'b0);
      for (int i = 0; i < 20; i++) send(32'(100 + i), 1'b0);
      idle(3);
      assert_eq("t3_count", wv_t'(a_q.size()), wv_t'(12));
      check_frame("t3_win_f1", 0, 0);
      check_frame("t3_win_f2", 100, 6);

      // reset in the middle of a frame
      for (int i = 0; i < 10; i++) send(32'(i), i == 0);
      @(negedge clk);
      valid_in = 1'b0;
      rst      = 1'b1;
      @(posedge clk);
      #1;
      assert_eq("t4_rst_win", pack_a(), wv_t'(0));
      assert_eq("t4_rst_valid", wv_t'(a_vld), wv_t'(0));
      assert_eq("t4_rst_full", pack_b(), wv_t'(0));
      @(negedge clk);
      rst = 1'b0;
      a_q.delete();
      for (int i = 0; i < 20; i++) send(32'(200 + i), 1'b0);
      idle(3);
      assert_eq("t4_count", wv_t'(a_q.size()), wv_t'(6));
      check_frame("t4_win", 200, 0);

      // sof_in aborting a partial frame
      a_q.delete();
      for (int i = 0; i < 8; i++) send(32'(i), i == 0);
      for (int i = 0; i < 20; i++) send(32'(300 + i), i == 0);
      idle(3);
      assert_eq("t5_count", wv_t'(a_q.size()), wv_t'(6));
      check_frame("t5_win", 300, 0);

      // full-size 28x28 frame of random words against a reference model
      b_q.delete();
      for (int i = 0; i < 784; i++) px[i] = $urandom;
      for (int i = 0; i < 784; i++) send(px[i], i == 0);
      idle(3);
      assert_eq("t6_count", wv_t'(b_q.size()), wv_t'(676));
      for (int idx = 0; idx < 676; idx++) begin
         int  r, c;
         wv_t v;
         r = 2 + idx / 26;
         c = 2 + idx % 26;
         v = wv_t'(idx == 675);
         for (int k = 0; k < 9; k++)
            v = (v << 32) | wv_t'(px[(r - 2 + k / 3) * 28 + (c - 2 + k % 3)]);
         if (idx < b_q.size()) assert_eq("t6_win", b_q[idx], v);
      end

      assert_eq("fl_without_valid", wv_t'(fl_bad), wv_t'(0));
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
